// File: rtl/kt_pkg.sv
// Shared constants for the 5x5 knight's-tour stream checker.
package kt_pkg;

   localparam int unsigned BOARD_DIM = 5;
   localparam int unsigned N_CELLS   = BOARD_DIM * BOARD_DIM;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CHECK  = 2'd1;
   localparam logic [1:0] S_REPORT = 2'd2;

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_OOB       = 3'd1;
   localparam logic [2:0] ERR_BAD_INDEX = 3'd2;
   localparam logic [2:0] ERR_BAD_MOVE  = 3'd3;
   localparam logic [2:0] ERR_REVISIT   = 3'd4;
   localparam logic [2:0] ERR_SHORT     = 3'd5;
   localparam logic [2:0] ERR_LONG      = 3'd6;

   // Beat counter saturates one past the tour length so overruns stay visible.
   localparam logic [4:0] CNT_FULL = 5'(N_CELLS);
   localparam logic [4:0] CNT_MAX  = 5'(N_CELLS + 1);

endpackage

// File: rtl/kt_move_check.sv
// Combinational per-beat geometry: bounds, knight adjacency to the previous cell, cell index.
module kt_move_check
   import kt_pkg::*;
(
   input  logic [2:0] prev_x,
   input  logic [2:0] prev_y,
   input  logic [2:0] cur_x,
   input  logic [2:0] cur_y,
   output logic       oob,
   output logic       knight_ok,
   output logic [4:0] cell_idx
);

   logic signed [3:0] dx;
   logic signed [3:0] dy;
   logic [3:0]        adx;
   logic [3:0]        ady;

   always_comb begin
      oob = (cur_x >= 3'(BOARD_DIM)) || (cur_y >= 3'(BOARD_DIM));
      // Zero-extended 4-bit signed difference cannot wrap for 3-bit coordinates.
      dx  = $signed({1'b0, cur_x}) - $signed({1'b0, prev_x});
      dy  = $signed({1'b0, cur_y}) - $signed({1'b0, prev_y});
      adx = dx[3] ? 4'(-dx) : 4'(dx);
      ady = dy[3] ? 4'(-dy) : 4'(dy);
      knight_ok = ((adx == 4'd1) && (ady == 4'd2)) || ((adx == 4'd2) && (ady == 4'd1));
      cell_idx  = ({2'b00, cur_x} << 2) + {2'b00, cur_x} + {2'b00, cur_y};
   end

endmodule

// File: rtl/kt_tour_checker.sv
// Receive-side checker: consumes one solver step per cycle and reports one verdict per stream.
module kt_tour_checker
   import kt_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [2:0] in_x,
   input  logic [2:0] in_y,
   input  logic [4:0] move_in,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_code,
   output logic [4:0] err_step
);

   logic [1:0]  state;
   logic [24:0] visited;
   logic [4:0]  cnt;
   logic [2:0]  prev_x;
   logic [2:0]  prev_y;
   logic [2:0]  err_r;
   logic [4:0]  step_r;

   logic        oob;
   logic        knight_ok;
   logic [4:0]  cell_idx;

   logic        idle;
   logic        beat;
   logic [4:0]  cnt_cur;
   logic [24:0] vis_base;
   logic [24:0] vis_next;
   logic [2:0]  err_base;
   logic [4:0]  step_base;
   logic [2:0]  beat_code;
   logic [2:0]  err_next;
   logic [4:0]  step_next;
   logic [2:0]  final_code;
   logic [4:0]  final_step;

   kt_move_check u_move_check (
      .prev_x    (prev_x),
      .prev_y    (prev_y),
      .cur_x     (in_x),
      .cur_y     (in_y),
      .oob       (oob),
      .knight_ok (knight_ok),
      .cell_idx  (cell_idx)
   );

   // The beat taken in IDLE is beat 1 and must see cleared history, not the last stream's.
   always_comb begin
      idle      = (state == S_IDLE);
      beat      = in_valid && (state != S_REPORT);
      cnt_cur   = idle ? 5'd1 : ((cnt >= CNT_MAX) ? CNT_MAX : cnt + 5'd1);
      vis_base  = idle ? '0 : visited;
      err_base  = idle ? ERR_NONE : err_r;
      step_base = idle ? '0 : step_r;

      if (cnt_cur >= CNT_MAX)
         beat_code = ERR_LONG;
      else if (oob)
         beat_code = ERR_OOB;
      else if (move_in != cnt_cur)
         beat_code = ERR_BAD_INDEX;
      else if ((cnt_cur >= 5'd2) && !knight_ok)
         beat_code = ERR_BAD_MOVE;
      else if (vis_base[cell_idx])
         beat_code = ERR_REVISIT;
      else
         beat_code = ERR_NONE;

      vis_next = oob ? vis_base : (vis_base | (25'd1 << cell_idx));

      if ((err_base == ERR_NONE) && (beat_code != ERR_NONE)) begin
         err_next  = beat_code;
         step_next = cnt_cur;
      end else begin
         err_next  = err_base;
         step_next = step_base;
      end

      if (err_r != ERR_NONE) begin
         final_code = err_r;
         final_step = step_r;
      end else if (cnt < CNT_FULL) begin
         final_code = ERR_SHORT;
         final_step = cnt;
      end else begin
         final_code = ERR_NONE;
         final_step = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         visited  <= '0;
         cnt      <= '0;
         prev_x   <= '0;
         prev_y   <= '0;
         err_r    <= ERR_NONE;
         step_r   <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_code <= ERR_NONE;
         err_step <= '0;
      end else begin
         done <= 1'b0;

         if (beat) begin
            cnt     <= cnt_cur;
            visited <= vis_next;
            err_r   <= err_next;
            step_r  <= step_next;
            if (!oob) begin
               prev_x <= in_x;
               prev_y <= in_y;
            end
         end else if (idle) begin
            visited <= '0;
            cnt     <= '0;
            prev_x  <= '0;
            prev_y  <= '0;
            err_r   <= ERR_NONE;
            step_r  <= '0;
         end

         case (state)
            S_IDLE:   if (in_valid) state <= S_CHECK;
            S_CHECK:
               if (!in_valid) begin
                  state    <= S_REPORT;
                  done     <= 1'b1;
                  pass     <= (final_code == ERR_NONE);
                  err_code <= final_code;
                  err_step <= final_step;
               end
            S_REPORT: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule
